fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, sets the number of instruction buffer entries; legal values are 1 to 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 Port pc_in, input, 32 bits (register_t): the redirect target from the branch unit's pc_out.
REQ-006 Port pc_load, input, 1 bit: a one-cycle pulse that redirects fetch to pc_in.
REQ-007 Port imem_req, output, 1 bit: instruction memory read request.
REQ-008 Port imem_addr, output, 32 bits: the read address, always word aligned.
REQ-009 Port imem_gnt, input, 1 bit: memory accepts the request in this cycle.
REQ-010 Port imem_rvalid, input, 1 bit: read data is valid in this cycle.
REQ-011 Port imem_rdata, input, 32 bits: read data.
REQ-012 Port instr, output, 32 bits (instruction_t): the head instruction, sent to decode/execute.
REQ-013 Port instr_pc, output, 32 bits (register_t): the PC of the head instruction.
REQ-014 Port instr_valid, output, 1 bit: the buffer head is valid.
REQ-015 Port instr_ready, input, 1 bit: the consumer takes the head when both instr_valid and instr_ready are 1.

Function
REQ-016 The block SHALL keep a fetch PC (fpc) and a FIFO of DEPTH entries; each entry holds {instr, pc}.
REQ-017 The request FSM SHALL have three states: IDLE, REQ and WAIT.
- IDLE -> REQ when occupancy + outstanding < DEPTH.
- REQ -> WAIT on imem_gnt.
- WAIT -> IDLE on imem_rvalid.
REQ-018 At most one read SHALL be outstanding at a time.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the latched request address.
REQ-020 imem_addr SHALL stay stable from the cycle imem_req rises until imem_gnt is seen; a request is never withdrawn.
REQ-021 fpc SHALL increment by 4 on every grant, with 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
REQ-022 On imem_rvalid for a request that has not been killed, the block SHALL push {imem_rdata, request address} into the FIFO in that cycle.
REQ-023 instr_valid SHALL be 1 exactly when the FIFO is not empty.
REQ-024 instr and instr_pc SHALL be driven from registers at the FIFO head; their value is don't-care when instr_valid is 0.
REQ-025 When the FIFO is empty, a pushed entry SHALL appear on instr_valid in the next cycle, so rvalid to instr_valid latency is 1 cycle.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged; because of REQ-017 the FIFO never overflows.
REQ-027 On pc_load the block SHALL set fpc to {pc_in[31:2], 2'b00}, clear the FIFO and drop instr_valid in the next cycle.
REQ-028 pc_load in IDLE: imem_req SHALL assert with the new address in the next cycle.
REQ-029 pc_load in REQ or WAIT: the outstanding request SHALL complete normally and its response SHALL be discarded (kill flag).
- Fetch of the new address SHALL start from IDLE after that response.
REQ-030 pc_load in the same cycle as imem_rvalid SHALL discard that response.
REQ-031 pc_load in the same cycle as a pop: the flush SHALL take priority and the popped entry is simply consumed.
REQ-032 pc_load in the same cycle as imem_gnt SHALL kill the granted request; fpc takes the redirect value, not fpc + 4.
REQ-033 A second pc_load while the kill flag is set SHALL update fpc only; the flag stays set until the discarded response arrives.

Reset
REQ-034 While rst = 0 the block SHALL immediately set:
- FSM = IDLE, fpc = RESET_PC, FIFO empty, kill flag = 0;
- imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-035 imem_req SHALL assert with imem_addr = RESET_PC in the first cycle after rst is released.
REQ-036 rst asserted mid-transaction SHALL abandon the outstanding read; an rvalid arriving after reset is released with no request outstanding SHALL be ignored.

Verification
REQ-037 Reset release, memory with 1-cycle gnt and 1-cycle rvalid, instr_ready = 1 -> instr_pc sequence 0, 4, 8, ... with instr matching memory contents.
REQ-038 instr_ready = 0 held -> exactly DEPTH entries buffered, imem_req stays 0, no entry lost or duplicated after instr_ready returns to 1.
REQ-039 pc_load with pc_in = 32'h0000_0103 while in WAIT -> killed response not delivered; next instr_pc = 32'h0000_0100.
REQ-040 pc_load in the same cycle as imem_rvalid and as a pop -> buffer empty next cycle; the first delivered entry comes from the new target.
REQ-041 fpc = 32'hFFFF_FFFC -> next fetch address is 32'h0000_0000.
REQ-042 rst pulsed low while in REQ -> outputs cleared at once; imem_req with 32'h0000_0000 in the first cycle after release; a stray rvalid is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: request FSM with kill-on-redirect and a shift-register buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic [31:0]   pcs_q [DEPTH];
  logic [31:0]   pcs_d [DEPTH];

  logic [31:0] load_pc;
  logic        pop, push;
  logic        unused_pc_lsb;

  assign load_pc       = {pc_in[31:2], 2'b00};
  assign unused_pc_lsb = ^pc_in[1:0];

  assign instr_valid = (cnt_q != '0);
  assign instr       = ins_q[0];
  assign instr_pc    = pcs_q[0];
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;

  assign pop  = instr_valid && instr_ready;
  // A redirect in the response cycle discards that response as well.
  assign push = (state_q == WAIT) && imem_rvalid && !kill_q && !pc_load;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        if (pc_load) begin
          fpc_d   = load_pc;
          addr_d  = load_pc;
          state_d = REQ;
        end else if (cnt_q < DEPTH_C) begin
          addr_d  = fpc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          if (!kill_q && !pc_load) fpc_d = fpc_q + 32'd4;
        end
        if (pc_load) begin
          fpc_d  = load_pc;
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (pc_load) fpc_d = load_pc;
        if (imem_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else if (pc_load) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head, so instr/instr_pc come straight from registers.
  always_comb begin
    ins_d   = ins_q;
    pcs_d   = pcs_q;
    cnt_pop = cnt_q - CW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ins_d[i] = ins_q[i+1];
        pcs_d[i] = pcs_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_pop == CW'(i)) begin
          ins_d[i] = imem_rdata;
          pcs_d[i] = addr_q;
        end
      end
    end
    cnt_d = pc_load ? '0 : cnt_pop + CW'(push);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      pcs_q   <= pcs_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized memory responder with an in-order PC/instruction scoreboard for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NONE     = 32'hBAD0_BAD1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_load = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int unsigned gnt_pct, rv_pct, rdy_pct;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  logic        pend_stale[$];
  logic        cur_stale;
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return NONE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: decide and drive inputs at a falling edge, then check the state after the rising edge.
  task automatic cycle(input logic ld, input logic [31:0] ld_pc);
    logic g, rv, rdy, rv_stale, p_req, p_gnt, p_ld, p_push;
    logic [31:0] rv_addr, p_addr;
    rdy = ($urandom_range(99) < rdy_pct);
    g   = imem_req && ($urandom_range(99) < gnt_pct);
    rv  = (pend_addr.size() != 0) && ($urandom_range(99) < rv_pct);
    rv_addr = '0;
    rv_stale = 1'b1;
    if (rv) begin
      rv_addr  = pend_addr.pop_front();
      rv_stale = pend_stale.pop_front();
    end
    instr_ready = rdy;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rv ? memf(rv_addr) : $urandom();
    pc_load     = ld;
    pc_in       = ld_pc;
    if (instr_valid && rdy) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, memf(exp_pc));
      pop_log.push_back(instr_pc);
      exp_pc += 32'd4;
    end
    if (g) begin
      pend_addr.push_back(imem_addr);
      pend_stale.push_back(cur_stale);
      cur_stale = 1'b0;
    end else if (ld && imem_req) begin
      cur_stale = 1'b1;
    end
    if (ld) begin
      exp_pc = {ld_pc[31:2], 2'b00};
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
    end
    p_push = rv && !rv_stale && !ld && !instr_valid;
    p_req  = imem_req;
    p_gnt  = g;
    p_addr = imem_addr;
    p_ld   = ld;
    @(negedge clk);
    if (p_req && !p_gnt) begin
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, p_addr);
    end
    if (imem_req) begin
      chk("one_outstanding", 32'(pend_addr.size()), 0);
      chk("addr_align", 32'(imem_addr[1:0]), 0);
    end
    if (p_ld) chk("flush_valid", instr_valid, 0);
    if (p_push) begin
      chk("push_latency", instr_valid, 1);
      chk("push_pc", instr_pc, rv_addr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    pc_load = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rst_first_req", imem_req, 1);
    chk("rst_first_addr", imem_addr, RESET_PC);
    chk("stray_rvalid", instr_valid, 0);
    pend_addr.delete();
    pend_stale.delete();
    cur_stale = 1'b0;
    exp_pc = RESET_PC;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic any_req, ld;
    @(negedge clk);
    do_reset();

    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    pop_log.delete();
    repeat (30) cycle(1'b0, '0);
    chk("stream_first_pc", log_at(0), 32'h0);
    chk("stream_fourth_pc", log_at(3), 32'h0000_000C);
    chk("stream_progress", 32'(pop_log.size() >= 8), 1);

    rdy_pct = 0;
    repeat (40) cycle(1'b0, '0);
    any_req = 1'b0;
    repeat (10) begin
      any_req |= imem_req;
      cycle(1'b0, '0);
    end
    chk("full_no_req", any_req, 0);
    chk("full_valid", instr_valid, 1);
    gnt_pct = 0; rdy_pct = 100;
    pop_log.delete();
    repeat (10) cycle(1'b0, '0);
    chk("full_depth", 32'(pop_log.size()), DEPTH);

    gnt_pct = 100; rv_pct = 0;
    n = 0;
    while (pend_addr.size() == 0 && n < 20) begin cycle(1'b0, '0); n++; end
    chk("kill_reach_wait", 32'(pend_addr.size()), 1);
    cycle(1'b1, 32'h0000_0103);
    pop_log.delete();
    rv_pct = 100;
    repeat (20) cycle(1'b0, '0);
    chk("kill_next_pc", log_at(0), 32'h0000_0100);

    gnt_pct = 0; rdy_pct = 100;
    repeat (6) cycle(1'b0, '0);
    gnt_pct = 100; rdy_pct = 0;
    n = 0;
    while (!instr_valid && n < 20) begin cycle(1'b0, '0); n++; end
    rv_pct = 0;
    n = 0;
    while (pend_addr.size() == 0 && n < 20) begin cycle(1'b0, '0); n++; end
    chk("flush_setup", {30'd0, instr_valid, pend_addr.size() == 1}, 32'd3);
    rv_pct = 100; rdy_pct = 100;
    cycle(1'b1, 32'h0000_2000);
    pop_log.delete();
    repeat (20) cycle(1'b0, '0);
    chk("flush_next_pc", log_at(0), 32'h0000_2000);

    gnt_pct = 0;
    repeat (6) cycle(1'b0, '0);
    chk("gnt_load_setup", imem_req, 1);
    gnt_pct = 100; rv_pct = 0;
    cycle(1'b1, 32'h0000_0300);
    pop_log.delete();
    rv_pct = 100;
    repeat (20) cycle(1'b0, '0);
    chk("gnt_load_pc0", log_at(0), 32'h0000_0300);
    chk("gnt_load_pc1", log_at(1), 32'h0000_0304);

    rv_pct = 0;
    n = 0;
    while (pend_addr.size() == 0 && n < 20) begin cycle(1'b0, '0); n++; end
    cycle(1'b1, 32'h0000_0400);
    cycle(1'b1, 32'h0000_0501);
    pop_log.delete();
    rv_pct = 100;
    repeat (20) cycle(1'b0, '0);
    chk("double_load_pc", log_at(0), 32'h0000_0500);

    rdy_pct = 0;
    repeat (20) cycle(1'b0, '0);
    chk("idle_setup", imem_req, 0);
    cycle(1'b1, 32'hFFFF_FFF8);
    chk("idle_load_req", imem_req, 1);
    chk("idle_load_addr", imem_addr, 32'hFFFF_FFF8);
    pop_log.delete();
    rdy_pct = 100;
    repeat (25) cycle(1'b0, '0);
    chk("wrap_pc1", log_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", log_at(2), 32'h0000_0000);

    gnt_pct = 0;
    repeat (3) cycle(1'b0, '0);
    chk("pre_rst_req", imem_req, 1);
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    pop_log.delete();
    repeat (20) cycle(1'b0, '0);
    chk("post_rst_pc", log_at(0), RESET_PC);

    gnt_pct = 50; rv_pct = 50; rdy_pct = 60;
    repeat (700) begin
      ld = ($urandom_range(99) < 3);
      cycle(ld, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
